aes_key_sched: RTL
==================

Name: aes_key_sched

Overview:
- Sequential AES key-schedule engine. Expands a 128/192/256-bit cipher key into the full round-key table of 44, 52 or 60 words and holds it in an internal buffer.
- Produces `WordsPerCycle` schedule words per clock through one shared 4-byte S-box word.
- Has a start/ready/done handshake, a wipe command, and a combinational round-key read port with forward or inverse (decryption) round ordering.
- Sits beside the AES cipher core and replaces on-the-fly key expansion where round keys must be reused across blocks.

Parameters:
- AES192Enable, 1, 1 = AES-192 supported; 0 = AES_192 key length rejected as invalid.
- SBoxImpl, "lut", implementation string passed to the 4 aes_sbox instances (op fixed CIPH_FWD).
- WordsPerCycle, 1, schedule words generated per EXPAND cycle; legal values 1, 2, 4; other values are an elaboration error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request expansion; accepted only when ready_o=1.
- key_len_i  in  3  one-hot: 001=AES_128, 010=AES_192, 100=AES_256; sampled at start.
- key_i  in  256  cipher key; vector byte n = key_i[8n+:8]; word k = key_i[32k+:32]; sampled at start.
- clear_i  in  1  wipe buffer and abort any operation.
- ready_o  out  1  FSM in IDLE.
- busy_o  out  1  FSM in EXPAND.
- done_o  out  1  one-cycle pulse when the schedule completes.
- err_o  out  1  one-cycle pulse when a start carries an invalid key length.
- valid_o  out  1  buffer holds a complete schedule.
- rd_op_i  in  1  0=CIPH_FWD ordering, 1=CIPH_INV ordering.
- rd_round_i  in  4  logical round index to read.
- rd_key_o  out  128  round key; word 4p at [31:0], word 4p+3 at [127:96].

Behaviour:
- Derived constants from the latched key length: Nk = 4/6/8, Nr = 10/12/14, total words T = 44/52/60.
- Reset (rst_i=1, async) forces:
  - state IDLE; ready_o=1; busy_o, done_o, err_o, valid_o = 0;
  - buffer all zero; rcon = 01; word index = 0; latched key length = AES_128.
- FSM: IDLE -> EXPAND -> IDLE. There is no other state.
- IDLE, start_i=1, valid key length, at the clock edge:
  - latch key_len_i;
  - write words 0..Nk-1 from key_i;
  - idx <= Nk, rcon <= 01, valid_o <= 0;
  - state <= EXPAND.
- IDLE, start_i=1, invalid key length (not one-hot, or AES_192 with AES192Enable=0):
  - err_o=1 for the next cycle; state stays IDLE; valid_o <= 0.
  - Buffer contents are retained but unreadable while valid_o=0.
- EXPAND, each cycle, computes words j = idx .. idx+WordsPerCycle-1, clipped to j < T. Each word is chained combinationally on the previous one in the same cycle.
  - If j mod Nk = 0: temp = SubWord(RotWord(w[j-1])) ^ {24'h0, rcon}.
    - RotWord(x) = {x[7:0], x[31:8]}, i.e. byte 0 moves to byte 3.
    - rcon is XORed into byte 0.
    - rcon <= xtime(rcon) at the edge, so rcon follows 01,02,04,...,80,1b,36.
  - Else if Nk = 8 and j mod 8 = 4: temp = SubWord(w[j-1]).
  - Else: temp = w[j-1].
  - w[j] = w[j-Nk] ^ temp.
  - At most one SubWord per cycle is needed for all legal parameter values, so exactly 4 S-boxes are instantiated.
  - At the edge: idx <= idx + WordsPerCycle.
- Completion: on the edge that writes word T-1:
  - state <= IDLE; valid_o <= 1; done_o <= 1 for exactly one cycle.
- EXPAND cycle count = ceil((T-Nk)/WordsPerCycle):
  - WordsPerCycle=1: 40 / 46 / 52;
  - WordsPerCycle=2: 20 / 23 / 26;
  - WordsPerCycle=4: 10 / 12 / 13 (for AES-192 the last cycle writes only 2 words).
- start_i while busy_o=1 is ignored: no restart, no error.
- A start in the same cycle that done_o is high is accepted (state is IDLE).
- clear_i, in any state, highest priority, at the edge:
  - buffer zeroed; valid_o <= 0; state <= IDLE; idx <= 0; rcon <= 01;
  - done_o and err_o are not raised; a simultaneous start_i is ignored.
- Read port, combinational:
  - physical round p = rd_round_i when rd_op_i=0, or Nr - rd_round_i when rd_op_i=1;
  - rd_key_o = {w[4p+3], w[4p+2], w[4p+1], w[4p]};
  - rd_key_o = 0 when valid_o=0 or rd_round_i > Nr.
- Reset asserted mid-EXPAND aborts immediately to the reset values listed above.

Test Plan:
- AES-128, key bytes 00..0f, WordsPerCycle=1 -> busy_o for 40 cycles, then done_o pulse. rd_round_i=10, rd_op_i=0 -> bytes 13111d7fe3944a17f307a78b4d2b30c5; rd_round_i=0 returns the key.
- AES-192, key bytes 00..17, WordsPerCycle=4 -> 12 busy cycles. Round 12 = a4970a331a78dc09c418c271e3a41d5d; rd_op_i=1 with rd_round_i=0 returns the same value.
- AES-256, key bytes 00..1f, WordsPerCycle=2 -> 26 busy cycles. Round 14 = 24fc79ccbf0979e9371ac23c6d68de36; rd_round_i=15 -> 0.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> w[43] bytes b6 63 0c a6 (FIPS-197 A.1). Second start_i pulsed mid-expansion -> no effect on result or timing.
- key_len_i=011 -> err_o pulse, valid_o=0, rd_key_o=0. With AES192Enable=0, key_len_i=010 -> same response.
- clear_i at EXPAND cycle 5 together with start_i -> next cycle ready_o=1, valid_o=0, rd_key_o=0, no done_o. rst_i pulsed mid-expansion -> all outputs at reset values.

Source files
------------

// File: rtl/aes_key_sched.sv
// AES key-schedule engine: expands a 128/192/256-bit key into the full round-key
// table, WordsPerCycle words per clock, with a forward/inverse round-key read port.

module aes_sbox #(
  parameter SBoxImpl = "lut"
) (
  input  logic       op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  if (SBoxImpl != "lut") begin : g_bad_impl
    $error("aes_sbox: unsupported SBoxImpl");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  always_comb begin
    logic [7:0] x;
    logic [7:0] s;
    // NOTE: every variable written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    x      = 8'h00;
    s      = 8'h00;
    data_o = 8'h00;
    if (!op_i) begin
      x      = gf_inv(data_i);
      data_o = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end else begin
      s      = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^ {data_i[1:0], data_i[7:2]} ^ 8'h05;
      data_o = gf_inv(s);
    end
  end

endmodule

module aes_key_sched #(
  parameter bit AES192Enable  = 1'b1,
  parameter     SBoxImpl      = "lut",
  parameter int WordsPerCycle = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   key_len_i,
  input  logic [255:0] key_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         valid_o,
  input  logic         rd_op_i,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o
);

  if (!(WordsPerCycle == 1 || WordsPerCycle == 2 || WordsPerCycle == 4)) begin : g_bad_wpc
    $error("aes_key_sched: WordsPerCycle must be 1, 2 or 4");
  end

  localparam int NWords = 60;

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [NWords];
  logic [31:0] w_d [NWords];
  logic [6:0]  idx_q, idx_d;
  logic [2:0]  ph_q, ph_d;      // idx_q mod Nk, kept incrementally to avoid a divider
  logic [7:0]  rcon_q, rcon_d;
  logic [2:0]  klen_q, klen_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  nk, nr;
  logic [6:0]  tw;
  logic [31:0] sub_in, sub_out;
  logic [WordsPerCycle-1:0][31:0] new_w;
  logic [WordsPerCycle-1:0]       new_en;
  logic        rcon_step;

  function automatic logic [31:0] rd_word(input logic [6:0] j);
    return (j < 7'(NWords)) ? w_q[j[5:0]] : 32'h0;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    nk = 4'd4;
    nr = 4'd10;
    tw = 7'd44;
    if (klen_q[1]) begin
      nk = 4'd6;
      nr = 4'd12;
      tw = 7'd52;
    end else if (klen_q[2]) begin
      nk = 4'd8;
      nr = 4'd14;
      tw = 7'd60;
    end
  end

  // S-box input: a plain XOR chain is exact up to the (single) SubWord slot of
  // this cycle, so the S-box input never depends on its own output.
  always_comb begin : sbox_feed
    logic [31:0] chain;
    logic [6:0]  j;
    logic [3:0]  ph;
    sub_in = 32'h0;
    j      = 7'd0;
    chain  = rd_word(idx_q - 7'd1);
    ph     = {1'b0, ph_q};
    for (int k = 0; k < WordsPerCycle; k++) begin
      j = idx_q + 7'(k);
      if (j < tw) begin
        if (ph == 4'd0)                    sub_in = {chain[7:0], chain[31:8]};
        else if (nk == 4'd8 && ph == 4'd4) sub_in = chain;
        chain = rd_word(j - {3'b000, nk}) ^ chain;
      end
      ph = (ph + 4'd1 == nk) ? 4'd0 : ph + 4'd1;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox #(.SBoxImpl(SBoxImpl)) u_sbox (
      .op_i  (1'b0),
      .data_i(sub_in[8*b +: 8]),
      .data_o(sub_out[8*b +: 8])
    );
  end

  always_comb begin : expand_words
    logic [31:0] chain;
    logic [31:0] temp;
    logic [6:0]  j;
    logic [3:0]  ph;
    new_w     = '0;
    new_en    = '0;
    rcon_step = 1'b0;
    temp      = 32'h0;
    j         = 7'd0;
    chain     = rd_word(idx_q - 7'd1);
    ph        = {1'b0, ph_q};
    for (int k = 0; k < WordsPerCycle; k++) begin
      j = idx_q + 7'(k);
      if (j < tw) begin
        if (ph == 4'd0) begin
          temp      = sub_out ^ {24'h0, rcon_q};
          rcon_step = 1'b1;
        end else if (nk == 4'd8 && ph == 4'd4) begin
          temp = sub_out;
        end else begin
          temp = chain;
        end
        chain     = rd_word(j - {3'b000, nk}) ^ temp;
        new_w[k]  = chain;
        new_en[k] = 1'b1;
      end
      ph = (ph + 4'd1 == nk) ? 4'd0 : ph + 4'd1;
    end
  end

  always_comb begin : next_state
    logic       len_ok;
    logic [3:0] nk_new;
    logic [3:0] ph_sum;
    logic [6:0] j;
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    rcon_d  = rcon_q;
    klen_d  = klen_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    j       = 7'd0;
    ph_sum  = {1'b0, ph_q} + 4'(WordsPerCycle);
    len_ok  = (key_len_i == 3'b001) || (key_len_i == 3'b100) ||
              (key_len_i == 3'b010 && AES192Enable);
    nk_new  = key_len_i[2] ? 4'd8 : (key_len_i[1] ? 4'd6 : 4'd4);

    if (clear_i) begin
      for (int i = 0; i < NWords; i++) w_d[i] = 32'h0;
      valid_d = 1'b0;
      state_d = IDLE;
      idx_d   = 7'd0;
      ph_d    = 3'd0;
      rcon_d  = 8'h01;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            valid_d = 1'b0;
            if (len_ok) begin
              klen_d = key_len_i;
              for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_new) w_d[k] = key_i[32*k +: 32];
              end
              idx_d   = {3'b000, nk_new};
              ph_d    = 3'd0;
              rcon_d  = 8'h01;
              state_d = EXPAND;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        EXPAND: begin
          for (int k = 0; k < WordsPerCycle; k++) begin
            j = idx_q + 7'(k);
            if (new_en[k]) w_d[j[5:0]] = new_w[k];
          end
          idx_d  = idx_q + 7'(WordsPerCycle);
          ph_d   = (ph_sum >= nk) ? 3'(ph_sum - nk) : ph_sum[2:0];
          rcon_d = rcon_step ? xtime(rcon_q) : rcon_q;
          if (idx_q + 7'(WordsPerCycle) >= tw) begin
            state_d = IDLE;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the key buffer is reset explicitly because a freshly reset engine must
  // read back zeros, not whatever the flops powered up with.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value regardless of statement order.
      state_q <= IDLE;
      for (int i = 0; i < NWords; i++) w_q[i] <= 32'h0;
      idx_q   <= 7'd0;
      ph_q    <= 3'd0;
      rcon_q  <= 8'h01;
      klen_q  <= 3'b001;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      rcon_q  <= rcon_d;
      klen_q  <= klen_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == EXPAND);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;

  // Inverse ordering maps logical round r to physical round Nr - r.
  always_comb begin : read_port
    logic [3:0] p;
    p        = rd_op_i ? (nr - rd_round_i) : rd_round_i;
    rd_key_o = 128'h0;
    if (valid_q && rd_round_i <= nr) begin
      rd_key_o = {w_q[{p, 2'd3}], w_q[{p, 2'd2}], w_q[{p, 2'd1}], w_q[{p, 2'd0}]};
    end
  end

endmodule
